// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer ahead of the instruction register: owns the PC/nPC pair,
// runs the MOV/MFC read handshake and strobes the IR load.
module instr_fetch_ctrl #(
    parameter int                 ADDR_W   = 32,
    parameter int                 TIMEOUT  = 15,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_req,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] target,
    input  logic              mfc,
    output logic              mov,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ir_ld,
    output logic              fetch_done,
    output logic              fetch_err,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    localparam int             WCW       = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    logic [2:0]        state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, npc_reg, ram_addr_reg;
    logic [ADDR_W-1:0] pend_target_reg;
    logic              pend_reg;
    logic [WCW-1:0]    wait_cnt_reg;

    logic              redirect_hit;
    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] npc_next;
    logic              enter_req;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (fetch_req) state_next = ST_REQ;
            ST_REQ: begin
                // mfc wins over timeout when both land in the last wait cycle
                if (mfc)
                    state_next = ST_LOAD;
                else if (wait_cnt_reg == WAIT_LAST)
                    state_next = ST_ERR;
            end
            ST_LOAD: state_next = ST_DONE;
            ST_DONE: state_next = fetch_req ? ST_REQ : ST_IDLE;
            ST_ERR:  if (fetch_req) state_next = ST_REQ;
            default: state_next = ST_IDLE;
        endcase
    end

    // A redirect arriving in the DONE cycle itself overrides any older pending one
    assign redirect_hit    = redirect | pend_reg;
    assign redirect_target = redirect ? target : pend_target_reg;
    assign npc_next        = redirect_hit ? (redirect_target & WORD_MASK)
                                          : npc_reg + ADDR_W'(4);
    assign enter_req       = (state_next == ST_REQ) && (state_reg != ST_REQ);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= RESET_PC;
            npc_reg         <= RESET_PC + ADDR_W'(4);
            ram_addr_reg    <= '0;
            pend_reg        <= 1'b0;
            pend_target_reg <= '0;
            wait_cnt_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= (state_reg == ST_REQ) ? wait_cnt_reg + 1'b1 : '0;

            if (state_reg == ST_DONE) begin
                pc_reg   <= npc_reg;
                npc_reg  <= npc_next;
                pend_reg <= 1'b0;
            end else if (redirect) begin
                pend_reg        <= 1'b1;
                pend_target_reg <= target;
            end

            // Leaving DONE the read must use the PC that is being committed now
            if (enter_req)
                ram_addr_reg <= (state_reg == ST_DONE) ? npc_reg : pc_reg;
        end
    end

    assign mov        = (state_reg == ST_REQ) || (state_reg == ST_LOAD);
    assign ir_ld      = (state_reg == ST_LOAD);
    assign fetch_done = (state_reg == ST_DONE);
    assign fetch_err  = (state_reg == ST_ERR);
    assign ram_addr   = ram_addr_reg;
    assign pc         = pc_reg;
    assign npc        = npc_reg;

endmodule
